// File: rtl/tt_logic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : tt_logic_pkg                                                  |
// | Purpose  : Shared types and helpers for the reprogrammable truth-table   |
// |            logic unit: controller state encoding, table geometry        |
// |            helpers and the canonical 4-input test function 0x9591.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package tt_logic_pkg;

    // Controller state: normal evaluate/config vs. full-table sweep.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Canonical test function inherited from the fixed NOR/NOT netlists.
    localparam logic [15:0] c_tt_fn_9591 = 16'h9591;

    // Table depth in bits for an n_in-input function.
    function automatic int tt_depth(input int n_in);
        return 1 << n_in;
    endfunction

    // Number of config words needed to cover one table.
    function automatic int tt_words(input int n_in, input int load_w);
        return tt_depth(n_in) / load_w;
    endfunction

    // Select-field width for n choices; never narrower than one bit so the
    // port always exists, even when there is only a single choice.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tt_channel                                                    |
// | Purpose  : Storage for one N_IN-input truth table with a word-wide      |
// |            write port and a combinational single-bit read by index.     |
// | Ports    : clk, rst_n         - clock, asynchronous active-low reset     |
// |            wr_en             - write strobe (already qualified)         |
// |            wr_addr, wr_data  - word index and LOAD_W table bits         |
// |            rd_index          - input vector used as table index         |
// |            rd_bit            - table[rd_index], pre-write value         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tt_channel
    import tt_logic_pkg::*;
#(
    parameter int          N_IN     = 4,
    parameter int          LOAD_W   = 16,
    parameter logic [15:0] RESET_TT = 16'h0000
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         wr_en,
    input  logic [sel_width(tt_words(N_IN, LOAD_W))-1:0] wr_addr,
    input  logic [LOAD_W-1:0]                            wr_data,
    input  logic [N_IN-1:0]                              rd_index,
    output logic                                         rd_bit
);

    localparam int TT_D    = tt_depth(N_IN);
    localparam int N_WORDS = tt_words(N_IN, LOAD_W);
    localparam int ADDR_W  = sel_width(N_WORDS);

    // The 16-bit reset pattern is tiled across the table; small tables
    // simply keep its low bits.
    localparam logic [255:0]    c_reset_rep = {16{RESET_TT}};
    localparam logic [TT_D-1:0] c_reset_val = c_reset_rep[TT_D-1:0];

    logic [TT_D-1:0] r_table;

    // Only word indices that exist in the table match; any other address
    // (possible when the table is a single word) is silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_table <= c_reset_val;
        end else if (wr_en) begin
            for (int w = 0; w < N_WORDS; w++) begin
                if (wr_addr == ADDR_W'(w)) begin
                    r_table[w*LOAD_W +: LOAD_W] <= wr_data;
                end
            end
        end
    end

    // The index spans exactly TT_D entries, so the read never goes out of range.
    assign rd_bit = r_table[rd_index];

endmodule
`default_nettype wire

// File: rtl/tt_logic_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tt_logic_unit                                                 |
// | Purpose  : N_CH reloadable N_IN-input truth tables evaluated through a  |
// |            one-deep registered valid/ready output stage, with a sweep   |
// |            mode that emits every table index in order.                  |
// | Ports    : clk, rst_n                      - clock, async active-low rst|
// |            cfg_valid/ready, cfg_ch,         - table word write port     |
// |            cfg_addr, cfg_data                                           |
// |            in_valid/ready, in_vec           - evaluation request        |
// |            sweep_start, sweep_busy          - full-table sweep control  |
// |            out_valid/ready, out_bits,       - registered result stream  |
// |            out_index, out_last                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tt_logic_unit
    import tt_logic_pkg::*;
#(
    parameter int          N_IN     = 4,
    parameter int          N_CH     = 1,
    parameter int          LOAD_W   = 16,
    parameter logic [15:0] RESET_TT = 16'h0000
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cfg_valid,
    output logic                                         cfg_ready,
    input  logic [sel_width(N_CH)-1:0]                   cfg_ch,
    input  logic [sel_width(tt_words(N_IN, LOAD_W))-1:0] cfg_addr,
    input  logic [LOAD_W-1:0]                            cfg_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [N_IN-1:0]                              in_vec,
    input  logic                                         sweep_start,
    output logic                                         sweep_busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [N_CH-1:0]                              out_bits,
    output logic [N_IN-1:0]                              out_index,
    output logic                                         out_last
);

    localparam int TT_D    = tt_depth(N_IN);
    localparam int N_WORDS = tt_words(N_IN, LOAD_W);
    localparam int CH_W    = sel_width(N_CH);
    localparam int ADDR_W  = sel_width(N_WORDS);

    state_t            r_state;
    logic [N_IN-1:0]   r_counter;
    logic              r_out_valid;
    logic [N_CH-1:0]   r_out_bits;
    logic [N_IN-1:0]   r_out_index;
    logic              r_out_last;

    logic              w_idle;
    logic              w_out_free;
    logic              w_cfg_fire;
    logic              w_in_fire;
    logic              w_last_beat;
    logic [N_IN-1:0]   w_rd_index;
    logic [N_CH-1:0]   w_rd_bits;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_cfg_fire  = cfg_valid && cfg_ready;
    assign w_in_fire   = in_valid && in_ready;
    assign w_last_beat = (r_counter == N_IN'(TT_D - 1));

    // All channels share one read index: the request vector when idle,
    // the sweep counter while sweeping.
    assign w_rd_index  = w_idle ? in_vec : r_counter;

    assign cfg_ready   = w_idle;
    assign in_ready    = w_idle && w_out_free;
    assign sweep_busy  = (r_state == ST_SWEEP);
    assign out_valid   = r_out_valid;
    assign out_bits    = r_out_bits;
    assign out_index   = r_out_index;
    assign out_last    = r_out_last;

    // Channel reads are combinational from the pre-edge table, so an
    // evaluation accepted on the same edge as a write sees the old contents.
    // A cfg_ch beyond N_CH-1 matches no channel and the write is dropped.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        tt_channel #(
            .N_IN     (N_IN),
            .LOAD_W   (LOAD_W),
            .RESET_TT (RESET_TT)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (w_cfg_fire && (cfg_ch == CH_W'(c))),
            .wr_addr  (cfg_addr),
            .wr_data  (cfg_data),
            .rd_index (w_rd_index),
            .rd_bit   (w_rd_bits[c])
        );
    end

    // Controller, sweep counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_counter   <= '0;
            r_out_valid <= 1'b0;
            r_out_bits  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_fire) begin
                        r_out_valid <= 1'b1;
                        r_out_bits  <= w_rd_bits;
                        r_out_index <= in_vec;
                        r_out_last  <= 1'b0;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    // An evaluation on this edge still completes; the
                    // first sweep beat follows on the next free edge.
                    if (sweep_start) begin
                        r_state   <= ST_SWEEP;
                        r_counter <= '0;
                    end
                end

                ST_SWEEP: begin
                    // Advance only when the output stage can take a beat,
                    // so back-pressure neither drops nor repeats indices.
                    if (w_out_free) begin
                        r_out_valid <= 1'b1;
                        r_out_bits  <= w_rd_bits;
                        r_out_index <= r_counter;
                        r_out_last  <= w_last_beat;
                        r_counter   <= r_counter + 1'b1;
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_logic_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tt_logic_unit                                              |
// | Purpose  : Self-checking bench for tt_logic_unit (N_IN=4, N_CH=2,       |
// |            LOAD_W=8, RESET_TT=0x9591): a table-level reference model    |
// |            compared every cycle, plus directed literal expectations.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tt_logic_unit;

    localparam int          N_IN     = 4;
    localparam int          N_CH     = 2;
    localparam int          LOAD_W   = 8;
    localparam int          TT_D     = 16;
    localparam logic [15:0] RESET_TT = 16'h9591;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:0]        cfg_ch;
    logic [0:0]        cfg_addr;
    logic [7:0]        cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_vec;
    logic              sweep_start;
    logic              sweep_busy;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_bits;
    logic [3:0]        out_index;
    logic              out_last;

    int n_vec  = 0;
    int n_fail = 0;

    // Beats handed over downstream: {last, index[3:0], bits[1:0]}.
    logic [6:0] cap_q[$];

    // Reference model state.
    logic [15:0] m_tt [N_CH];
    bit          m_busy;
    int          m_cnt;
    bit          m_ov;
    logic [1:0]  m_ob;
    logic [3:0]  m_oi;
    bit          m_ol;

    always #5 clk = ~clk;

    tt_logic_unit #(
        .N_IN     (N_IN),
        .N_CH     (N_CH),
        .LOAD_W   (LOAD_W),
        .RESET_TT (RESET_TT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .out_index   (out_index),
        .out_last    (out_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] bits_at(input int idx);
        logic [1:0] r;
        for (int c = 0; c < N_CH; c++) r[c] = m_tt[c][idx];
        return r;
    endfunction

    // Model: tables as plain words, output stage as a one-entry holding slot.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) m_tt[c] = RESET_TT;
            m_busy = 0; m_cnt = 0; m_ov = 0; m_ob = '0; m_oi = '0; m_ol = 0;
        end else if (!m_busy) begin
            if (in_valid && (!m_ov || out_ready)) begin
                m_ov = 1; m_ob = bits_at(int'(in_vec)); m_oi = in_vec; m_ol = 0;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (cfg_valid)
                m_tt[cfg_ch][int'(cfg_addr)*LOAD_W +: LOAD_W] = cfg_data;
            if (sweep_start) begin
                m_busy = 1; m_cnt = 0;
            end
        end else if (!m_ov || out_ready) begin
            m_ov = 1; m_ob = bits_at(m_cnt); m_oi = 4'(m_cnt); m_ol = (m_cnt == TT_D - 1);
            if (m_ol) begin m_busy = 0; m_cnt = 0; end
            else m_cnt++;
        end
    end

    // Per-cycle comparison against the model, plus capture of handed-over beats.
    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_bits",  32'(out_bits),  32'(m_ob));
            chk("out_index", 32'(out_index), 32'(m_oi));
            chk("out_last",  32'(out_last),  32'(m_ol));
        end
        chk("in_ready",   32'(in_ready),   32'(!m_busy && (!m_ov || out_ready)));
        chk("cfg_ready",  32'(cfg_ready),  32'(!m_busy));
        chk("sweep_busy", 32'(sweep_busy), 32'(m_busy));
        if (rst_n && out_valid && out_ready)
            cap_q.push_back({out_last, out_index, out_bits});
    end

    task automatic eval_lit(input logic [3:0] v, input logic [1:0] e);
        @(posedge clk); #1; in_valid = 1; in_vec = v;
        @(posedge clk); #1; in_valid = 0;
        chk("eval_valid", 32'(out_valid), 32'd1);
        chk("eval_bits",  32'(out_bits),  32'(e));
        chk("eval_index", 32'(out_index), 32'(v));
        chk("eval_last",  32'(out_last),  32'd0);
    endtask

    task automatic cfg_write(input logic ch, input logic addr, input logic [7:0] d);
        @(posedge clk); #1; cfg_valid = 1; cfg_ch = ch; cfg_addr = addr; cfg_data = d;
        @(posedge clk); #1; cfg_valid = 0;
    endtask

    // Sweep and check the captured beats against the expected tables.
    // With bp set: random back-pressure, a repeated start pulse, a config
    // write and an eval request while the sweep is running.
    task automatic run_sweep(input bit bp, input logic [15:0] t0, input logic [15:0] t1);
        int n = 0;
        @(posedge clk); #1; sweep_start = 1;
        @(posedge clk); #1; sweep_start = 0; cap_q.delete();
        while (n < 400 && !(cap_q.size() > 0 && cap_q[$][6])) begin
            if (bp) begin
                out_ready = ($urandom_range(0, 2) != 0);
                case (n)
                    2: sweep_start = 1;
                    3: sweep_start = 0;
                    4: begin cfg_valid = 1; cfg_ch = 0; cfg_addr = 1; cfg_data = 8'hAA;
                             in_valid = 1; in_vec = 4'd2; end
                    8: begin cfg_valid = 0; in_valid = 0; end
                    default: ;
                endcase
            end
            @(posedge clk); #1; n++;
        end
        out_ready = 1; sweep_start = 0; cfg_valid = 0; in_valid = 0;
        chk("sweep_timeout", 32'(n < 400), 32'd1);
        chk("sweep_beats", 32'(cap_q.size()), 32'd16);
        foreach (cap_q[i]) begin
            chk("sweep_idx",  32'(cap_q[i][5:2]), 32'(i));
            chk("sweep_last", 32'(cap_q[i][6]),   32'(i == 15));
            chk("sweep_bits", 32'(cap_q[i][1:0]), 32'({t1[i], t0[i]}));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 0; cfg_valid = 0; cfg_ch = 0; cfg_addr = 0; cfg_data = '0;
        in_valid = 0; in_vec = '0; sweep_start = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_bits",   32'(out_bits),   32'd0);
        chk("rst_out_index",  32'(out_index),  32'd0);
        chk("rst_out_last",   32'(out_last),   32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_cfg_ready",  32'(cfg_ready),  32'd1);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        @(posedge clk); #1; rst_n = 1;

        // Both channels hold 0x9591 after reset.
        eval_lit(4'd0,  2'b11);
        eval_lit(4'd1,  2'b00);
        eval_lit(4'd4,  2'b11);
        eval_lit(4'd7,  2'b11);
        eval_lit(4'd10, 2'b11);
        eval_lit(4'd15, 2'b11);

        // ch0 := 0x0000, ch1 := 0x0F0F, then ch1 := 0x9591 word by word.
        cfg_write(1'b0, 1'b0, 8'h00);
        cfg_write(1'b0, 1'b1, 8'h00);
        cfg_write(1'b1, 1'b0, 8'h0F);
        cfg_write(1'b1, 1'b1, 8'h0F);
        eval_lit(4'd0, 2'b10);
        eval_lit(4'd4, 2'b00);
        cfg_write(1'b1, 1'b0, 8'h91);
        cfg_write(1'b1, 1'b1, 8'h95);
        run_sweep(1'b0, 16'h0000, 16'h9591);

        // Write and evaluate on the same edge: the eval sees the old table.
        @(posedge clk); #1;
        cfg_valid = 1; cfg_ch = 0; cfg_addr = 0; cfg_data = 8'hFF;
        in_valid = 1; in_vec = 4'd1;
        @(posedge clk); #1; cfg_valid = 0; in_valid = 0;
        chk("same_cycle_bits", 32'(out_bits), 32'd0);
        eval_lit(4'd1, 2'b01);

        // Stalled sweep; the write of 0xAA to ch0 word 1 must be refused.
        run_sweep(1'b1, 16'h00FF, 16'h9591);
        eval_lit(4'd9, 2'b00);
        eval_lit(4'd3, 2'b01);

        // Reset in the middle of a sweep.
        @(posedge clk); #1; sweep_start = 1;
        @(posedge clk); #1; sweep_start = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && out_index == 4'd5) && n < 100);
        chk("beat5_timeout", 32'(n < 100), 32'd1);
        #2; rst_n = 0; #1;
        chk("midrst_out_valid",  32'(out_valid),  32'd0);
        chk("midrst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("midrst_cfg_ready",  32'(cfg_ready),  32'd1);
        chk("midrst_out_index",  32'(out_index),  32'd0);
        @(posedge clk); #1; rst_n = 1;
        eval_lit(4'd8, 2'b11);
        eval_lit(4'd1, 2'b00);
        run_sweep(1'b0, 16'h9591, 16'h9591);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_logic_unit.md
# tt_logic_unit

Parametrised, reprogrammable truth-table logic unit: the successor to the team's fixed 4-input NOR/NOT netlists named by hex truth table (e.g. function 0x9591). Holds N_CH independent N_IN-input truth tables, loaded at run time over a config port. It evaluates input vectors through a registered valid/ready pipeline and can sweep all 2^N_IN input combinations to dump full truth tables for checking against synthesised gate netlists. It sits between the design-exploration test harness and the netlist models as a golden, reloadable reference function.

## Interface
Parameters:
- N_IN, 4: inputs per function; table depth TT_D = 2^N_IN bits per channel (1..8).
- N_CH, 1: independent channels/truth tables (1..8).
- LOAD_W, 16: config data word width; TT_D must be a multiple of LOAD_W.
- RESET_TT, 16'h0000: truth table every channel takes at reset (replicated; low TT_D bits used).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_ch  in  clog2(N_CH) (min 1)  target channel.
- cfg_addr  in  clog2(TT_D/LOAD_W) (min 1)  word index in the table.
- cfg_data  in  LOAD_W  table bits; bit k = entry addr*LOAD_W+k.
- in_valid  in  1  evaluation request.
- in_ready  out  1  evaluation accepted.
- in_vec  in  N_IN  input vector; used directly as table index.
- sweep_start  in  1  single-cycle pulse: start full-table sweep.
- sweep_busy  out  1  sweep in progress.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_bits  out  N_CH  bit c = table_c[index].
- out_index  out  N_IN  index that produced out_bits.
- out_last  out  1  final beat of a sweep; 0 for normal evaluations.

## Operation
- States: IDLE (normal eval + config), SWEEP.
- Tables: N_CH x TT_D flops, reset to RESET_TT.
- Config: write occurs on cfg_valid && cfg_ready. cfg_ready = (state==IDLE); it is 0 throughout SWEEP. An out-of-range cfg_ch or cfg_addr is accepted and dropped.
- Eval (IDLE): accepted on in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). The result is registered into out_bits/out_index with out_last=0.
- Same-cycle config write + eval accept: the eval reads the OLD table. The new value applies from the next cycle.
- sweep_start in IDLE, arriving together with an eval accept: the eval is taken first. The sweep starts the next cycle, with counter = 0 and state = SWEEP.
- sweep_start while in SWEEP is ignored.
- SWEEP: each time the output stage is free (!out_valid || out_ready), emit index = counter, out_bits from the current tables, then increment the counter.
  - On the counter==TT_D-1 beat: out_last=1, return to IDLE, counter wraps to 0.
  - Holds under back-pressure; no beats are skipped or duplicated.
- sweep_busy = (state==SWEEP).
- Output: out_bits, out_index and out_last stay stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid=0, out_bits=0, out_index=0, out_last=0, sweep_busy=0, cfg_ready=1 (combinational from IDLE), in_ready=1, state=IDLE, counter=0, tables=RESET_TT.
- Eval latency: 1 cycle (accept at edge n, out_valid high after edge n). Full throughput: 1 result/cycle with out_ready held high.
- Sweep: the first beat is valid 1 cycle after the start-accept edge. With no back-pressure, TT_D beats arrive on consecutive cycles. in_ready and cfg_ready are 0 from the cycle after the start-accept edge until the edge that registers the last beat.
- Reset asserted mid-sweep or mid-transfer: everything returns to reset values immediately. The in-flight beat is lost and the tables revert to RESET_TT.

## Structure
- Package tt_logic_pkg: state enum (IDLE, SWEEP), TT_D/word-count helper functions, and the 0x9591 constant used as the canonical test function.
- Sub-module tt_channel (one per channel, generate loop): table storage, word write port, combinational read mux by index.
- The top level holds the FSM, sweep counter and output register.

## Test plan
- Reset with RESET_TT=16'h9591, N_IN=4, N_CH=1. Evaluate in_vec = 0, 1, 4, 7, 10, 15 -> out_bits = 1, 0, 1, 1, 1, 1. Each appears 1 cycle after accept, with out_last=0.
- N_CH=2, LOAD_W=8:
  - Write ch1 addr0=8'h91 and addr1=8'h95, then sweep -> 16 beats with out_index 0..15. out_bits[1] matches 0x9591; out_last=1 only on index 15.
  - Same-cycle write of ch0 addr0=8'hFF with eval in_vec=1 (old table 0x0000) -> out_bits[0]=0. Evaluating in_vec=1 again -> 1.
- Sweep with out_ready toggling pseudo-randomly -> exactly 16 beats, indices strictly increasing, outputs stable while stalled. cfg_ready and in_ready stay 0 throughout.
- sweep_start re-pulsed mid-sweep -> ignored, still 16 beats total. A cfg write attempted during the sweep is not accepted; the table is unchanged.
- rst_n dropped at sweep beat 5 -> out_valid=0 and sweep_busy=0 immediately, tables = RESET_TT. A new sweep afterwards starts at index 0.
